// File: rtl/rk4_combine.sv
// rk4_combine: final RK4 combine stage, y_next = y + h*(k1 + 2*k2 + 2*k3 + k4)/6
// in signed Q16.16. Slopes arrive over a valid/ready handshake, the product is
// formed in one cycle and divided by 6 with a bit-serial restoring divider. The
// result is presented with a one-cycle load strobe.
// Optional feature macro: RK_SAT_EN. When defined, the result saturates and OVF
// reports the clamp. When undefined, the result wraps and OVF is tied low.
module rk4_combine #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16,
  parameter int EXT   = 4
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             START,
  input  logic [WIDTH-1:0] y_in,
  input  logic [WIDTH-1:0] h_in,
  input  logic [WIDTH-1:0] k_in,
  input  logic             K_VALID,
  output logic             K_READY,
  output logic [WIDTH-1:0] y_out,
  output logic             LD_OUT,
  output logic             BUSY,
  output logic             OVF
);

  // Accumulator/quotient width and full product width.
  localparam int AW = WIDTH + EXT;
  localparam int PW = AW + WIDTH;
  localparam logic [5:0] DIV_LAST = 6'(AW - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_MUL,
    S_DIV,
    S_ADD,
    S_OUT
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] y_reg;
  logic [WIDTH-1:0] h_reg;
  logic [AW-1:0]    acc_reg;
  logic [1:0]       kidx_reg;
  // Shift register: dividend bits leave at the top while quotient bits enter at the bottom.
  logic [AW-1:0]    quo_reg;
  logic [2:0]       rem_reg;
  logic             neg_reg;
  logic [5:0]       cnt_reg;
  logic             k_ready_reg;
  logic             ld_reg;
  logic             busy_reg;
  logic             ovf_reg;
  logic [WIDTH-1:0] y_out_reg;

  // Slope weighting 1,2,2,1 on the sign-extended input.
  logic [AW-1:0] k_ext;
  logic [AW-1:0] k_weighted [4];

  assign k_ext = {{EXT{k_in[WIDTH-1]}}, k_in};

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_weight
    if (gi == 1 || gi == 2) begin : g_x2
      assign k_weighted[gi] = {k_ext[AW-2:0], 1'b0};
    end else begin : g_x1
      assign k_weighted[gi] = k_ext;
    end
  end

  // Full signed product acc*h. Both operands are sign-extended to PW, so the
  // low PW bits of the unsigned multiply equal the two's complement product.
  logic [PW-1:0] prod_full;
  logic [AW-1:0] p_val;
  logic [AW-1:0] p_abs;

  assign prod_full = {{WIDTH{acc_reg[AW-1]}}, acc_reg} * {{AW{h_reg[WIDTH-1]}}, h_reg};
  // Realign to Q16.16 by dropping FRAC fraction bits, then keep AW bits.
  assign p_val     = AW'(prod_full >> FRAC);
  assign p_abs     = p_val[AW-1] ? (AW'(0) - p_val) : p_val;

  // One restoring-divide step by 6.
  logic [3:0]    div_trial;
  logic          div_ge;
  logic [2:0]    rem_next;
  logic [AW-1:0] quo_next;

  assign div_trial = {rem_reg, quo_reg[AW-1]};
  assign div_ge    = (div_trial >= 4'd6);
  assign rem_next  = div_ge ? 3'(div_trial - 4'd6) : div_trial[2:0];
  assign quo_next  = {quo_reg[AW-2:0], div_ge};

  // Put the sign back on the magnitude quotient. This gives truncation toward zero.
  logic [AW-1:0] q_signed;
  assign q_signed = neg_reg ? (AW'(0) - quo_reg) : quo_reg;

  logic [WIDTH-1:0] result_val;
  logic             ovf_val;

`ifdef RK_SAT_EN
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic             q_fits;
  logic [WIDTH-1:0] q_clamp;
  logic [WIDTH:0]   sum_w;
  logic             sum_fits;

  // The quotient fits in WIDTH bits when all of its top EXT+1 bits agree.
  assign q_fits   = (q_signed[AW-1:WIDTH-1] == {(EXT+1){q_signed[AW-1]}});
  assign q_clamp  = q_fits ? q_signed[WIDTH-1:0] : (q_signed[AW-1] ? SMIN : SMAX);
  assign sum_w    = {y_reg[WIDTH-1], y_reg} + {q_clamp[WIDTH-1], q_clamp};
  assign sum_fits = (sum_w[WIDTH] == sum_w[WIDTH-1]);
  assign result_val = sum_fits ? sum_w[WIDTH-1:0] : (sum_w[WIDTH] ? SMIN : SMAX);
  assign ovf_val    = !q_fits || !sum_fits;
`else
  logic [AW:0] sum_w;

  assign sum_w      = {{(EXT+1){y_reg[WIDTH-1]}}, y_reg} + {q_signed[AW-1], q_signed};
  assign result_val = WIDTH'(sum_w);
  assign ovf_val    = 1'b0;
`endif

  // Sequencer: collect slopes, multiply, serial divide, add, strobe the result.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_reg   <= S_IDLE;
      y_reg       <= '0;
      h_reg       <= '0;
      acc_reg     <= '0;
      kidx_reg    <= '0;
      quo_reg     <= '0;
      rem_reg     <= '0;
      neg_reg     <= 1'b0;
      cnt_reg     <= '0;
      k_ready_reg <= 1'b0;
      ld_reg      <= 1'b0;
      busy_reg    <= 1'b0;
      ovf_reg     <= 1'b0;
      y_out_reg   <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (START) begin
            y_reg       <= y_in;
            h_reg       <= h_in;
            acc_reg     <= '0;
            kidx_reg    <= '0;
            k_ready_reg <= 1'b1;
            busy_reg    <= 1'b1;
            state_reg   <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (K_VALID && k_ready_reg) begin
            acc_reg  <= acc_reg + k_weighted[kidx_reg];
            kidx_reg <= kidx_reg + 2'd1;
            if (kidx_reg == 2'd3) begin
              k_ready_reg <= 1'b0;
              state_reg   <= S_MUL;
            end
          end
        end
        S_MUL: begin
          quo_reg   <= p_abs;
          neg_reg   <= p_val[AW-1];
          rem_reg   <= '0;
          cnt_reg   <= '0;
          state_reg <= S_DIV;
        end
        S_DIV: begin
          quo_reg <= quo_next;
          rem_reg <= rem_next;
          cnt_reg <= cnt_reg + 6'd1;
          if (cnt_reg == DIV_LAST) begin
            state_reg <= S_ADD;
          end
        end
        S_ADD: begin
          y_out_reg <= result_val;
          ovf_reg   <= ovf_val;
          ld_reg    <= 1'b1;
          state_reg <= S_OUT;
        end
        S_OUT: begin
          ld_reg    <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg   <= S_IDLE;
          k_ready_reg <= 1'b0;
          ld_reg      <= 1'b0;
          busy_reg    <= 1'b0;
        end
      endcase
    end
  end

  assign K_READY = k_ready_reg;
  assign y_out   = y_out_reg;
  assign LD_OUT  = ld_reg;
  assign BUSY    = busy_reg;
  assign OVF     = ovf_reg;

endmodule

// File: tb/tb_rk4_combine.sv
// Testbench for rk4_combine. It runs table vectors with hand-derived results,
// randomized updates checked against an arithmetic reference model, and
// hand-written sequences for stalls, START during OUT, and CLR during the divide.
module tb_rk4_combine;

  logic        CLK = 1'b0;
  logic        CLR;
  logic        START;
  logic [31:0] y_in;
  logic [31:0] h_in;
  logic [31:0] k_in;
  logic        K_VALID;
  logic        K_READY;
  logic [31:0] y_out;
  logic        LD_OUT;
  logic        BUSY;
  logic        OVF;

  int n_checks = 0;
  int n_fail   = 0;

  rk4_combine dut (
    .CLK     (CLK),
    .CLR     (CLR),
    .START   (START),
    .y_in    (y_in),
    .h_in    (h_in),
    .k_in    (k_in),
    .K_VALID (K_VALID),
    .K_READY (K_READY),
    .y_out   (y_out),
    .LD_OUT  (LD_OUT),
    .BUSY    (BUSY),
    .OVF     (OVF)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic [31:0] y;
    logic [31:0] h;
    logic [31:0] k0;
    logic [31:0] k1;
    logic [31:0] k2;
    logic [31:0] k3;
    logic [31:0] exp_y;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic [31:0] y, input logic [31:0] h,
                         input logic [31:0] k0, input logic [31:0] k1,
                         input logic [31:0] k2, input logic [31:0] k3,
                         input logic [31:0] exp_y, input logic exp_ovf);
    vec_t v;
    v.name = name; v.y = y; v.h = h;
    v.k0 = k0; v.k1 = k1; v.k2 = k2; v.k3 = k3;
    v.exp_y = exp_y; v.exp_ovf = exp_ovf;
    vecs.push_back(v);
  endtask

  // Reference: exact arithmetic with wide integers. Keep 36 bits of the Q16.16
  // product, divide with truncation toward zero, then add and either wrap or clamp.
  function automatic void ref_model(input logic [31:0] y, input logic [31:0] h,
                                    input logic [31:0] k0, input logic [31:0] k1,
                                    input logic [31:0] k2, input logic [31:0] k3,
                                    output logic [31:0] ry, output logic rov);
    logic signed [127:0] acc, prod, pf, qq, yy, sum;
    logic signed [35:0]  p36, q36;
    acc  = 128'($signed(k0)) + 128'($signed(k1)) + 128'($signed(k1))
         + 128'($signed(k2)) + 128'($signed(k2)) + 128'($signed(k3));
    prod = acc * 128'($signed(h));
    pf   = prod >>> 16;
    p36  = pf[35:0];
    q36  = p36 / 36'sd6;
    qq   = 128'(q36);
    yy   = 128'($signed(y));
    rov  = 1'b0;
`ifdef RK_SAT_EN
    if (qq > 128'sd2147483647) begin
      qq = 128'sd2147483647; rov = 1'b1;
    end else if (qq < -128'sd2147483648) begin
      qq = -128'sd2147483648; rov = 1'b1;
    end
    sum = yy + qq;
    if (sum > 128'sd2147483647) begin
      sum = 128'sd2147483647; rov = 1'b1;
    end else if (sum < -128'sd2147483648) begin
      sum = -128'sd2147483648; rov = 1'b1;
    end
`else
    sum = yy + qq;
`endif
    ry = sum[31:0];
  endfunction

  task automatic start_op(input logic [31:0] y, input logic [31:0] h);
    START = 1'b1; y_in = y; h_in = h;
    @(negedge CLK);
    START = 1'b0; y_in = $urandom; h_in = $urandom;
  endtask

  task automatic send_ks(input logic [31:0] k0, input logic [31:0] k1,
                         input logic [31:0] k2, input logic [31:0] k3,
                         input int gap, input bit start_in_gap);
    logic [31:0] ks [4];
    int guard;
    ks[0] = k0; ks[1] = k1; ks[2] = k2; ks[3] = k3;
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < gap; g++) begin
        K_VALID = 1'b0; k_in = $urandom; START = start_in_gap; y_in = $urandom;
        @(negedge CLK);
        START = 1'b0;
      end
      K_VALID = 1'b1; k_in = ks[i];
      guard = 0;
      while (K_READY !== 1'b1 && guard < 50) begin
        @(negedge CLK);
        guard++;
      end
      if (guard >= 50) check("k_ready_timeout", 32'(guard), 32'd0);
      @(negedge CLK);
    end
    K_VALID = 1'b0; k_in = '0;
  endtask

  // Called on the negedge right after the edge that accepted k4. That negedge
  // is counted as cycle 1.
  task automatic wait_result(input bit start_in_out, output logic [31:0] yo,
                             output logic ov, output int lat);
    logic [31:0] held;
    lat = 1;
    while (LD_OUT !== 1'b1 && lat < 200) begin
      @(negedge CLK);
      lat++;
    end
    yo = y_out; ov = OVF; held = y_out;
    if (start_in_out) begin
      START = 1'b1; y_in = 32'h1234_0000;
    end
    @(negedge CLK);
    START = 1'b0;
    check("ld_one_cycle", 32'(LD_OUT), 32'd0);
    check("busy_after_out", 32'(BUSY), 32'd0);
    check("kready_after_out", 32'(K_READY), 32'd0);
    check("y_out_held", y_out, held);
  endtask

  task automatic full_run(input string name, input logic [31:0] y, input logic [31:0] h,
                          input logic [31:0] k0, input logic [31:0] k1,
                          input logic [31:0] k2, input logic [31:0] k3,
                          input int gap, input bit start_in_gap, input bit start_in_out,
                          input logic [31:0] exp_y, input logic exp_ovf);
    logic [31:0] yo;
    logic        ov;
    int          lat;
    start_op(y, h);
    send_ks(k0, k1, k2, k3, gap, start_in_gap);
    wait_result(start_in_out, yo, ov, lat);
    check({name, "_y"}, yo, exp_y);
    check({name, "_ovf"}, 32'(ov), 32'(exp_ovf));
    check({name, "_latency"}, 32'(lat), 32'd39);
    $display("run %s: y_out=0x%08h ovf=%0b latency=%0d", name, yo, ov, lat);
  endtask

  initial begin
    logic [31:0] ry, ty, th, tk0, tk1, tk2, tk3;
    logic        rov;
    int          seen;

    CLR = 1'b1; START = 1'b0; y_in = '0; h_in = '0; k_in = '0; K_VALID = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset_y_out", y_out, 32'd0);
    check("reset_ld", 32'(LD_OUT), 32'd0);
    check("reset_kready", 32'(K_READY), 32'd0);
    check("reset_busy", 32'(BUSY), 32'd0);
    check("reset_ovf", 32'(OVF), 32'd0);
    CLR = 1'b0;
    @(negedge CLK);

    add_vec("nominal",  32'h0001_0000, 32'h0000_8000, 32'h0001_0000, 32'h0001_0000,
            32'h0001_0000, 32'h0001_0000, 32'h0001_8000, 1'b0);
    add_vec("negative", 32'h0000_0000, 32'h0001_0000, 32'hFFFF_0000, 32'hFFFF_0000,
            32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 1'b0);
    add_vec("trunc",    32'h0002_0000, 32'h0001_0000, 32'h0000_0000, 32'hFFFF_FFFF,
            32'h0000_0000, 32'h0000_0000, 32'h0002_0000, 1'b0);
    add_vec("ends_wt",  32'h0005_0000, 32'h0001_0000, 32'h0003_0000, 32'h0000_0000,
            32'h0000_0000, 32'h0003_0000, 32'h0006_0000, 1'b0);
    add_vec("neg_h",    32'h0000_0000, 32'hFFFF_0000, 32'h0001_0000, 32'h0001_0000,
            32'h0001_0000, 32'h0001_0000, 32'hFFFF_0000, 1'b0);
    add_vec("ulp_pos",  32'h0000_0000, 32'h0001_0000, 32'h0000_0000, 32'h0000_0000,
            32'h0000_0003, 32'h0000_0000, 32'h0000_0001, 1'b0);
    add_vec("ulp_neg",  32'h0000_0000, 32'h0001_0000, 32'h0000_0000, 32'hFFFF_FFFD,
            32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0);
`ifdef RK_SAT_EN
    add_vec("overflow", 32'h7FFF_0000, 32'h0001_0000, 32'h0006_0000, 32'h0006_0000,
            32'h0006_0000, 32'h0006_0000, 32'h7FFF_FFFF, 1'b1);
`else
    add_vec("overflow", 32'h7FFF_0000, 32'h0001_0000, 32'h0006_0000, 32'h0006_0000,
            32'h0006_0000, 32'h0006_0000, 32'h8005_0000, 1'b0);
`endif

    foreach (vecs[i]) begin
      full_run(vecs[i].name, vecs[i].y, vecs[i].h, vecs[i].k0, vecs[i].k1,
               vecs[i].k2, vecs[i].k3, 0, 1'b0, 1'b0, vecs[i].exp_y, vecs[i].exp_ovf);
    end

    // Stalled handshake with START pulses during COLLECT and START held in OUT.
    full_run("stall", 32'h0001_0000, 32'h0000_8000, 32'h0001_0000, 32'h0001_0000,
             32'h0001_0000, 32'h0001_0000, 2, 1'b1, 1'b1, 32'h0001_8000, 1'b0);
    check("start_in_out_ignored_y", y_out, 32'h0001_8000);

    // CLR during DIV cycle 10. Negedge n=1 follows the k4 edge, and DIV cycle 1 is n=2.
    start_op(32'h0001_0000, 32'h0000_8000);
    send_ks(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 0, 1'b0);
    repeat (10) @(negedge CLK);
    check("busy_mid_div", 32'(BUSY), 32'd1);
    CLR = 1'b1;
    @(negedge CLK);
    CLR = 1'b0;
    check("clr_y_out", y_out, 32'd0);
    check("clr_ld", 32'(LD_OUT), 32'd0);
    check("clr_busy", 32'(BUSY), 32'd0);
    check("clr_kready", 32'(K_READY), 32'd0);
    check("clr_ovf", 32'(OVF), 32'd0);
    seen = 0;
    repeat (60) begin
      @(negedge CLK);
      if (LD_OUT === 1'b1) seen++;
    end
    check("clr_no_strobe", 32'(seen), 32'd0);
    $display("run clr_mid_div: strobes after abort=%0d", seen);
    full_run("after_clr", 32'h0001_0000, 32'h0000_8000, 32'h0001_0000, 32'h0001_0000,
             32'h0001_0000, 32'h0001_0000, 0, 1'b0, 1'b0, 32'h0001_8000, 1'b0);

    // Randomized updates checked against the reference model.
    for (int r = 0; r < 24; r++) begin
      ty  = $urandom;
      th  = (r % 2 == 0) ? $urandom : ($urandom & 32'h0003_FFFF);
      tk0 = $urandom; tk1 = $urandom; tk2 = $urandom; tk3 = $urandom;
      if (r % 3 == 0) begin
        tk0 = {{12{tk0[19]}}, tk0[19:0]};
        tk1 = {{12{tk1[19]}}, tk1[19:0]};
        tk2 = {{12{tk2[19]}}, tk2[19:0]};
        tk3 = {{12{tk3[19]}}, tk3[19:0]};
      end
      ref_model(ty, th, tk0, tk1, tk2, tk3, ry, rov);
      full_run("random", ty, th, tk0, tk1, tk2, tk3, int'($urandom_range(0, 2)),
               1'b0, 1'b0, ry, rov);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
